// File: rtl/axi_tdd_sync_gen_if.sv
// Control/status bundle between the TDD register block (master) and the sync generator (slave).
interface axi_tdd_sync_gen_if #(
    parameter int SYNC_COUNT_WIDTH = 64
);
    logic                        tdd_enable;
    logic                        sync_ext_en;
    logic                        sync_ext_pol;
    logic                        sync_in;
    logic                        sync_soft;
    logic                        sync_int_en;
    logic [SYNC_COUNT_WIDTH-1:0] asy_sync_period;
    logic                        tdd_sync;
    logic [SYNC_COUNT_WIDTH-1:0] sync_counter;

    modport master (
        output tdd_enable, sync_ext_en, sync_ext_pol, sync_in, sync_soft,
               sync_int_en, asy_sync_period,
        input  tdd_sync, sync_counter
    );

    modport slave (
        input  tdd_enable, sync_ext_en, sync_ext_pol, sync_in, sync_soft,
               sync_int_en, asy_sync_period,
        output tdd_sync, sync_counter
    );
endinterface

// File: rtl/axi_tdd_sync_gen.sv
// Merges synchronized external edges, software strobes and an internal periodic generator into one tdd_sync pulse.
// Internal generator is built only when AXI_TDD_SYNC_INT_EN is defined; otherwise sync_counter is tied to 0.
module axi_tdd_sync_gen #(
    parameter int SYNC_COUNT_WIDTH = 64,
    parameter int SYNC_PIPE        = 3
) (
    input  logic              clk,
    input  logic              resetn,
    axi_tdd_sync_gen_if.slave sif
);

    logic [SYNC_PIPE-1:0] r_sync_pipe;
    logic                 r_sync_hist;
    logic                 r_ext_pulse;
    logic                 r_tdd_sync;
    logic                 w_sync_s;
    logic                 w_ext_edge;
    logic                 w_int_pulse;

    assign w_sync_s   = r_sync_pipe[SYNC_PIPE-1];
    assign w_ext_edge = sif.sync_ext_pol ? (r_sync_hist & ~w_sync_s)
                                         : (w_sync_s & ~r_sync_hist);

    // Pipe and history clear to 0, so a level held high through reset yields one rising event.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sync_pipe <= '0;
            r_sync_hist <= 1'b0;
            r_ext_pulse <= 1'b0;
            r_tdd_sync  <= 1'b0;
        end else begin
            r_sync_pipe <= {r_sync_pipe[SYNC_PIPE-2:0], sif.sync_in};
            r_sync_hist <= w_sync_s;
            r_ext_pulse <= sif.sync_ext_en & w_ext_edge;
            r_tdd_sync  <= sif.tdd_enable & (r_ext_pulse | w_int_pulse | sif.sync_soft);
        end
    end

    assign sif.tdd_sync = r_tdd_sync;

`ifdef AXI_TDD_SYNC_INT_EN
    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t                      r_state;
    logic [SYNC_COUNT_WIDTH-1:0] r_sync_period;
    logic [SYNC_COUNT_WIDTH-1:0] r_sync_counter;
    logic                        w_run_ok;

    assign w_run_ok = sif.tdd_enable & sif.sync_int_en & (r_sync_period != '0);

    // >= rather than == so a period shrunk below the running count wraps on the next cycle.
    assign w_int_pulse = (r_state == ST_RUN) &&
                         (r_sync_counter >= (r_sync_period - SYNC_COUNT_WIDTH'(1)));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state        <= ST_IDLE;
            r_sync_period  <= '0;
            r_sync_counter <= '0;
        end else begin
            if (sif.tdd_enable) begin
                r_sync_period <= sif.asy_sync_period;
            end
            case (r_state)
                ST_IDLE: begin
                    r_sync_counter <= '0;
                    if (w_run_ok) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!w_run_ok) begin
                        r_state        <= ST_IDLE;
                        r_sync_counter <= '0;
                    end else if (w_int_pulse) begin
                        r_sync_counter <= '0;
                    end else begin
                        r_sync_counter <= r_sync_counter + SYNC_COUNT_WIDTH'(1);
                    end
                end
            endcase
        end
    end

    assign sif.sync_counter = r_sync_counter;
`else
    logic w_unused_int;

    assign w_unused_int     = ^{sif.asy_sync_period, sif.sync_int_en};
    assign w_int_pulse      = 1'b0;
    assign sif.sync_counter = '0;
`endif

endmodule

// File: tb/tb_axi_tdd_sync_gen.sv
// Scoreboarded directed bench: stimulus pushes the cycle each tdd_sync pulse is due, a negedge monitor pops and compares.
module tb_axi_tdd_sync_gen;

    logic clk = 1'b0;
    logic resetn;
    int   cyc = 0;
    int   exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   done = 1'b0;

    axi_tdd_sync_gen_if #(.SYNC_COUNT_WIDTH(64)) bus ();

    axi_tdd_sync_gen #(
        .SYNC_COUNT_WIDTH(64),
        .SYNC_PIPE       (3)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .sif   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!done) begin
            while (exp_q.size() > 0 && exp_q[0] < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_pulse: tdd_sync stayed 0 in cycle %0d, required 1", exp_q[0]);
                void'(exp_q.pop_front());
            end
            if (bus.tdd_sync === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse: tdd_sync=1 in cycle %0d, required 0", cyc);
                end else if (exp_q[0] != cyc) begin
                    n_fail++;
                    $display("FAIL early_pulse: tdd_sync=1 in cycle %0d, next pulse due in cycle %0d",
                             cyc, exp_q[0]);
                end else begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k;
        resetn               = 1'b0;
        bus.tdd_enable       = 1'b1;
        bus.sync_ext_en      = 1'b1;
        bus.sync_ext_pol     = 1'b0;
        bus.sync_in          = 1'b1;
        bus.sync_soft        = 1'b0;
        bus.sync_int_en      = 1'b0;
        bus.asy_sync_period  = '0;
        tick(3);
        chk("reset_tdd_sync", {63'd0, bus.tdd_sync}, 64'd0);
        chk("reset_sync_counter", bus.sync_counter, 64'd0);

        // sync_in held high through reset: one rising event once the pipe refills
        resetn = 1'b1;
        exp_q.push_back(cyc + 5);
        tick(10);
        bus.sync_in = 1'b0;
        tick(10);

        // soft strobe, then the same with tdd_enable low (dropped)
        bus.sync_soft = 1'b1;
        exp_q.push_back(cyc + 1);
        tick(1);
        bus.sync_soft = 1'b0;
        tick(4);
        bus.tdd_enable = 1'b0;
        bus.sync_soft  = 1'b1;
        tick(1);
        bus.sync_soft  = 1'b0;
        tick(3);
        bus.tdd_enable = 1'b1;
        tick(2);

        // rising polarity: pulse on rise only
        bus.sync_in = 1'b1;
        exp_q.push_back(cyc + 5);
        tick(10);
        bus.sync_in = 1'b0;
        tick(10);

        // falling polarity: pulse on fall only
        bus.sync_ext_pol = 1'b1;
        tick(2);
        bus.sync_in = 1'b1;
        tick(10);
        bus.sync_in = 1'b0;
        exp_q.push_back(cyc + 5);
        tick(10);

        // external disabled, then edge while tdd_enable low: both dropped
        bus.sync_ext_pol = 1'b0;
        bus.sync_ext_en  = 1'b0;
        bus.sync_in      = 1'b1;
        tick(10);
        bus.sync_in      = 1'b0;
        tick(10);
        bus.sync_ext_en  = 1'b1;
        bus.tdd_enable   = 1'b0;
        bus.sync_in      = 1'b1;
        tick(10);
        bus.tdd_enable   = 1'b1;
        tick(5);
        bus.sync_in      = 1'b0;
        tick(10);

`ifdef AXI_TDD_SYNC_INT_EN
        // period 5
        bus.asy_sync_period = 64'd5;
        tick(2);
        k = cyc;
        bus.sync_int_en = 1'b1;
        exp_q.push_back(k + 6);
        exp_q.push_back(k + 11);
        exp_q.push_back(k + 16);
        tick(3);
        chk("counter_period5", bus.sync_counter, 64'd2);
        tick(14);
        bus.sync_int_en = 1'b0;
        tick(2);
        chk("counter_idle", bus.sync_counter, 64'd0);

        // period 1: pulse every cycle, counter pinned at 0
        k = cyc;
        bus.asy_sync_period = 64'd1;
        bus.sync_int_en     = 1'b1;
        for (int i = 2; i <= 5; i++) exp_q.push_back(k + i);
        tick(3);
        chk("counter_period1", bus.sync_counter, 64'd0);
        tick(1);
        bus.sync_int_en = 1'b0;
        tick(5);

        // period 100 shrunk to 10 at count 50
        k = cyc;
        bus.asy_sync_period = 64'd100;
        bus.sync_int_en     = 1'b1;
        exp_q.push_back(k + 53);
        exp_q.push_back(k + 63);
        exp_q.push_back(k + 73);
        tick(51);
        chk("counter_before_shrink", bus.sync_counter, 64'd50);
        bus.asy_sync_period = 64'd10;
        tick(2);
        chk("counter_after_shrink", bus.sync_counter, 64'd0);
        tick(21);
        bus.sync_int_en = 1'b0;
        tick(3);

        // soft strobe coincident with terminal count: one pulse
        k = cyc;
        bus.asy_sync_period = 64'd4;
        bus.sync_int_en     = 1'b1;
        exp_q.push_back(k + 5);
        tick(4);
        bus.sync_soft = 1'b1;
        tick(1);
        bus.sync_soft = 1'b0;
        tick(1);
        bus.sync_int_en = 1'b0;
        tick(4);

        // reset mid-period with a coincident soft strobe
        k = cyc;
        bus.asy_sync_period = 64'd8;
        bus.sync_int_en     = 1'b1;
        exp_q.push_back(k + 15);
        exp_q.push_back(k + 23);
        tick(4);
        chk("counter_before_reset", bus.sync_counter, 64'd3);
        resetn        = 1'b0;
        bus.sync_soft = 1'b1;
        tick(1);
        resetn        = 1'b1;
        bus.sync_soft = 1'b0;
        chk("tdd_sync_after_reset", {63'd0, bus.tdd_sync}, 64'd0);
        chk("counter_after_reset", bus.sync_counter, 64'd0);
        tick(19);
        bus.sync_int_en = 1'b0;
        tick(4);
`else
        // generator absent: no internal pulses, counter tied to 0
        bus.asy_sync_period = 64'd5;
        bus.sync_int_en     = 1'b1;
        tick(3);
        chk("counter_tied_a", bus.sync_counter, 64'd0);
        tick(20);
        chk("counter_tied_b", bus.sync_counter, 64'd0);

        resetn        = 1'b0;
        bus.sync_soft = 1'b1;
        tick(1);
        resetn        = 1'b1;
        bus.sync_soft = 1'b0;
        chk("tdd_sync_after_reset", {63'd0, bus.tdd_sync}, 64'd0);
        chk("counter_after_reset", bus.sync_counter, 64'd0);
        bus.sync_soft = 1'b1;
        exp_q.push_back(cyc + 1);
        tick(1);
        bus.sync_soft = 1'b0;
        tick(10);
        chk("counter_tied_c", bus.sync_counter, 64'd0);
        bus.sync_int_en = 1'b0;
`endif

        tick(5);
        done = 1'b1;
        chk("pending_pulses", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
